// File: rtl/alu_op_issuer.sv
// ALU op issuer: decodes RV32 opcode/funct3/funct7 into a 3-bit ALU op, evaluates it,
// and presents results through a 2-entry in-order output buffer with valid/ready on both sides.
module alu_op_issuer #(
    parameter int WIDTH     = 32,
    parameter int BUF_DEPTH = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [6:0]       opcode,
    input  logic [2:0]       funct3,
    input  logic [6:0]       funct7,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [2:0]       alu_op,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             taken,
    output logic             illegal
);

    typedef struct packed {
        logic [2:0]       op;
        logic [WIDTH-1:0] res;
        logic             zero;
        logic             taken;
        logic             ill;
    } entry_t;

    localparam logic [1:0] FULL_CNT = BUF_DEPTH[1:0];

    logic [2:0]       dec_op_s;
    logic             dec_ill_s;
    logic             is_br_s;
    logic             is_bne_s;
    logic [WIDTH-1:0] b_eff_s;
    logic [WIDTH-1:0] sum_s;
    logic             lt_s;
    logic [WIDTH-1:0] alu_res_s;
    entry_t           new_s;

    entry_t     slot0_q, slot0_d;
    entry_t     slot1_q, slot1_d;
    logic [1:0] count_q, count_d;
    logic       rdy_en_q;
    logic       push_s;
    logic       pop_s;

    // Instruction field decode into ALU op plus branch qualifiers.
    always_comb begin
        dec_op_s  = 3'b010;
        dec_ill_s = 1'b0;
        is_br_s   = 1'b0;
        is_bne_s  = 1'b0;
        case (opcode)
            7'b0110011: begin
                case (funct3)
                    3'b000: begin
                        if (funct7 == 7'b0000000) begin
                            dec_op_s = 3'b010;
                        end else if (funct7 == 7'b0100000) begin
                            dec_op_s = 3'b110;
                        end else begin
                            dec_ill_s = 1'b1;
                        end
                    end
                    3'b111:  if (funct7 == 7'b0000000) dec_op_s = 3'b000; else dec_ill_s = 1'b1;
                    3'b110:  if (funct7 == 7'b0000000) dec_op_s = 3'b001; else dec_ill_s = 1'b1;
                    3'b010:  if (funct7 == 7'b0000000) dec_op_s = 3'b111; else dec_ill_s = 1'b1;
                    default: dec_ill_s = 1'b1;
                endcase
            end
            7'b0010011: begin
                case (funct3)
                    3'b000:  dec_op_s  = 3'b010;
                    3'b111:  dec_op_s  = 3'b000;
                    3'b110:  dec_op_s  = 3'b001;
                    3'b010:  dec_op_s  = 3'b111;
                    default: dec_ill_s = 1'b1;
                endcase
            end
            7'b0000011, 7'b0100011: dec_op_s = 3'b010;
            7'b1100011: begin
                case (funct3)
                    3'b000: begin
                        dec_op_s = 3'b110;
                        is_br_s  = 1'b1;
                    end
                    3'b001: begin
                        dec_op_s = 3'b110;
                        is_br_s  = 1'b1;
                        is_bne_s = 1'b1;
                    end
                    default: dec_ill_s = 1'b1;
                endcase
            end
            default: dec_ill_s = 1'b1;
        endcase
    end

    // Shared adder; signed less-than taken from the operand signs when they differ,
    // otherwise from the difference, which cannot overflow in that case.
    always_comb begin
        b_eff_s = dec_op_s[2] ? ~b : b;
        sum_s   = a + b_eff_s + {{(WIDTH-1){1'b0}}, dec_op_s[2]};
        if (a[WIDTH-1] != b[WIDTH-1]) begin
            lt_s = a[WIDTH-1];
        end else begin
            lt_s = sum_s[WIDTH-1];
        end
        case (dec_op_s[1:0])
            2'b00:   alu_res_s = a & b;
            2'b01:   alu_res_s = a | b;
            2'b10:   alu_res_s = sum_s;
            2'b11:   alu_res_s = {{(WIDTH-1){1'b0}}, lt_s};
            default: alu_res_s = sum_s;
        endcase
    end

    // Assemble the entry to be buffered; illegal encodings carry a fixed neutral payload.
    always_comb begin
        new_s.op = dec_op_s;
        if (dec_ill_s) begin
            new_s.res   = {WIDTH{1'b0}};
            new_s.zero  = 1'b1;
            new_s.taken = 1'b0;
            new_s.ill   = 1'b1;
        end else begin
            new_s.res   = alu_res_s;
            new_s.zero  = (alu_res_s == {WIDTH{1'b0}});
            new_s.taken = is_br_s & (is_bne_s ^ new_s.zero);
            new_s.ill   = 1'b0;
        end
    end

    assign push_s = in_valid & in_ready;
    assign pop_s  = out_ready & (count_q != 2'd0);

    // Buffer update: slot0 is the head; it only shifts when a second entry exists,
    // so a drained head keeps its last data.
    always_comb begin
        slot0_d = slot0_q;
        slot1_d = slot1_q;
        count_d = count_q;
        if (pop_s && (count_q == 2'd2)) begin
            slot0_d = slot1_q;
        end else begin
            slot0_d = slot0_q;
        end
        if (push_s) begin
            if ((count_q == 2'd0) || (pop_s && (count_q == 2'd1))) begin
                slot0_d = new_s;
            end else begin
                slot1_d = new_s;
            end
        end else begin
            slot1_d = slot1_q;
        end
        count_d = count_q + {1'b0, push_s} - {1'b0, pop_s};
    end

    // State registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            slot0_q  <= '0;
            slot1_q  <= '0;
            count_q  <= 2'd0;
            rdy_en_q <= 1'b0;
        end else begin
            slot0_q  <= slot0_d;
            slot1_q  <= slot1_d;
            count_q  <= count_d;
            rdy_en_q <= 1'b1;
        end
    end

    assign in_ready  = rdy_en_q & (count_q != FULL_CNT);
    assign out_valid = (count_q != 2'd0);
    assign alu_op    = slot0_q.op;
    assign result    = slot0_q.res;
    assign zero      = slot0_q.zero;
    assign taken     = slot0_q.taken;
    assign illegal   = slot0_q.ill;

endmodule

// File: tb/tb_alu_op_issuer.sv
// Directed bench for alu_op_issuer: reference model feeds a scoreboard queue on every
// accepted input; entries are popped and compared whenever the DUT hands one out.
module tb_alu_op_issuer;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        in_valid;
    logic        in_ready;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] a;
    logic [31:0] b;
    logic        out_valid;
    logic        out_ready;
    logic [2:0]  alu_op;
    logic [31:0] result;
    logic        zero;
    logic        taken;
    logic        illegal;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] res;
        logic        zero;
        logic        taken;
        logic        ill;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    int          pops   = 0;

    alu_op_issuer #(.WIDTH(32), .BUF_DEPTH(2)) dut (
        .clk(clk), .reset_n(reset_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .opcode(opcode), .funct3(funct3), .funct7(funct7), .a(a), .b(b),
        .out_valid(out_valid), .out_ready(out_ready),
        .alu_op(alu_op), .result(result), .zero(zero), .taken(taken), .illegal(illegal)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    function automatic exp_t model(input logic [6:0] opc, input logic [2:0] f3,
                                   input logic [6:0] f7, input logic [31:0] x,
                                   input logic [31:0] y);
        exp_t e;
        int   kind;  // 0 and, 1 or, 2 add, 3 sub, 4 slt, 5 beq, 6 bne, -1 illegal
        kind = -1;
        if (opc == 7'b0110011) begin
            if (f7 == 7'h00 && f3 == 3'd0) kind = 2;
            else if (f7 == 7'h20 && f3 == 3'd0) kind = 3;
            else if (f7 == 7'h00 && f3 == 3'd7) kind = 0;
            else if (f7 == 7'h00 && f3 == 3'd6) kind = 1;
            else if (f7 == 7'h00 && f3 == 3'd2) kind = 4;
        end else if (opc == 7'b0010011) begin
            if (f3 == 3'd0) kind = 2;
            else if (f3 == 3'd7) kind = 0;
            else if (f3 == 3'd6) kind = 1;
            else if (f3 == 3'd2) kind = 4;
        end else if (opc == 7'b0000011 || opc == 7'b0100011) begin
            kind = 2;
        end else if (opc == 7'b1100011) begin
            if (f3 == 3'd0) kind = 5;
            else if (f3 == 3'd1) kind = 6;
        end
        e.taken = 1'b0;
        e.ill   = 1'b0;
        case (kind)
            0:       begin e.op = 3'b000; e.res = x & y; end
            1:       begin e.op = 3'b001; e.res = x | y; end
            2:       begin e.op = 3'b010; e.res = x + y; end
            3, 5, 6: begin e.op = 3'b110; e.res = x - y; end
            4:       begin e.op = 3'b111; e.res = ($signed(x) < $signed(y)) ? 32'd1 : 32'd0; end
            default: begin e.op = 3'b010; e.res = 32'd0; e.ill = 1'b1; end
        endcase
        e.zero = (e.res == 32'd0);
        if (kind == 5) e.taken = e.zero;
        if (kind == 6) e.taken = !e.zero;
        return e;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [6:0] opc, input logic [2:0] f3, input logic [6:0] f7,
                         input logic [31:0] x, input logic [31:0] y);
        in_valid = 1'b1;
        opcode   = opc;
        funct3   = f3;
        funct7   = f7;
        a        = x;
        b        = y;
    endtask

    // One clock: sample/compare on the falling edge, then step past the rising edge.
    task automatic cycle();
        exp_t e;
        @(negedge clk);
        if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
                chk("unexpected_output", 64'd1, 64'd0);
            end else begin
                e = sb.pop_front();
                pops++;
                chk("alu_op", 64'(alu_op), 64'(e.op));
                chk("result", 64'(result), 64'(e.res));
                chk("zero", 64'(zero), 64'(e.zero));
                chk("taken", 64'(taken), 64'(e.taken));
                chk("illegal", 64'(illegal), 64'(e.ill));
            end
        end
        if (in_valid && in_ready) sb.push_back(model(opcode, funct3, funct7, a, b));
        @(posedge clk);
        #1;
    endtask

    // Single transaction into an empty buffer; it must be out one cycle later.
    task automatic send1(input string tag, input logic [6:0] opc, input logic [2:0] f3,
                         input logic [6:0] f7, input logic [31:0] x, input logic [31:0] y);
        drive(opc, f3, f7, x, y);
        cycle();
        in_valid = 1'b0;
        cycle();
        chk({tag, "_latency"}, 64'(sb.size()), 64'd0);
    endtask

    initial begin
        logic [31:0] hold_r;
        int          pops0;
        reset_n   = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        opcode    = 7'd0;
        funct3    = 3'd0;
        funct7    = 7'd0;
        a         = 32'd0;
        b         = 32'd0;
        #12;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        chk("rst_alu_op", 64'(alu_op), 64'd0);
        chk("rst_result", 64'(result), 64'd0);
        chk("rst_zero", 64'(zero), 64'd0);
        chk("rst_taken", 64'(taken), 64'd0);
        chk("rst_illegal", 64'(illegal), 64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        chk("in_ready_after_release", 64'(in_ready), 64'd1);
        out_ready = 1'b1;

        send1("sub",       7'b0110011, 3'b000, 7'b0100000, 32'd5, 32'd7);
        send1("add_wrap",  7'b0110011, 3'b000, 7'b0000000, 32'hFFFFFFFF, 32'd1);
        send1("slt_neg",   7'b0110011, 3'b010, 7'b0000000, 32'hFFFFFFFF, 32'd1);
        send1("slti_ovf",  7'b0010011, 3'b010, 7'b1010101, 32'h7FFFFFFF, 32'h80000000);
        send1("beq",       7'b1100011, 3'b000, 7'b0000000, 32'h1234, 32'h1234);
        send1("bne",       7'b1100011, 3'b001, 7'b0000000, 32'h1234, 32'h1234);
        send1("bne_diff",  7'b1100011, 3'b001, 7'b0000000, 32'h1234, 32'h1235);
        send1("br_f3_100", 7'b1100011, 3'b100, 7'b0000000, 32'h1, 32'h2);
        send1("lw",        7'b0000011, 3'b010, 7'b0000000, 32'h1000, 32'hFFFFFFFC);
        send1("r_bad_f7",  7'b0110011, 3'b111, 7'b0100000, 32'hF0, 32'hFF);

        // Backpressure: third transaction must wait until a slot frees.
        out_ready = 1'b0;
        drive(7'b0110011, 3'b111, 7'b0000000, 32'hF0F0F0F0, 32'hFF00FF00);
        cycle();
        drive(7'b0110011, 3'b110, 7'b0000000, 32'h0000000F, 32'h000000F0);
        cycle();
        drive(7'b0010011, 3'b000, 7'b0000000, 32'd100, 32'hFFFFFFFF);
        chk("bp_in_ready_full", 64'(in_ready), 64'd0);
        chk("bp_head_first", 64'(result), 64'hF000F000);
        hold_r = result;
        cycle();
        cycle();
        chk("bp_hold_result", 64'(result), 64'(hold_r));
        chk("bp_hold_valid", 64'(out_valid), 64'd1);
        chk("bp_no_accept_full", 64'(sb.size()), 64'd2);
        out_ready = 1'b1;
        cycle();
        chk("bp_in_ready_rise", 64'(in_ready), 64'd1);
        cycle();
        in_valid = 1'b0;
        cycle();
        chk("bp_drained", 64'(sb.size()), 64'd0);

        // Throughput: ten back-to-back mixed ops must emerge on consecutive cycles.
        pops0 = pops;
        for (int i = 0; i < 10; i++) begin
            case (i % 4)
                0:       drive(7'b0110011, 3'b111, 7'b0000000, $urandom, $urandom);
                1:       drive(7'b0110011, 3'b110, 7'b0000000, $urandom, $urandom);
                2:       drive(7'b0010011, 3'b000, 7'(i), $urandom, $urandom);
                default: drive(7'b0100011, 3'b010, 7'b0000000, $urandom, $urandom);
            endcase
            cycle();
        end
        in_valid = 1'b0;
        cycle();
        chk("throughput_pops", 64'(pops - pops0), 64'd10);
        chk("throughput_drained", 64'(sb.size()), 64'd0);
        send1("illegal_opc", 7'b1111111, 3'b000, 7'b0000000, 32'hDEAD, 32'hBEEF);

        // Reset with two entries buffered discards them.
        out_ready = 1'b0;
        drive(7'b0110011, 3'b000, 7'b0000000, 32'd1, 32'd2);
        cycle();
        drive(7'b0110011, 3'b000, 7'b0000000, 32'd3, 32'd4);
        cycle();
        in_valid = 1'b0;
        chk("pre_reset_valid", 64'(out_valid), 64'd1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("mid_reset_out_valid", 64'(out_valid), 64'd0);
        chk("mid_reset_result", 64'(result), 64'd0);
        chk("mid_reset_in_ready", 64'(in_ready), 64'd0);
        sb.delete();
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        chk("post_reset_in_ready", 64'(in_ready), 64'd1);
        out_ready = 1'b1;
        pops0 = pops;
        repeat (3) cycle();
        chk("post_reset_no_stale", 64'(pops - pops0), 64'd0);
        chk("post_reset_out_valid", 64'(out_valid), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
